// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel pipeline: colours,
// default active area and the bounce direction encoding.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 1024;
   localparam int V_ACTIVE_DEF = 768;

   localparam logic [23:0] COL_BLANK = 24'h000000;
   localparam logic [23:0] COL_BG    = 24'hB93E06;
   localparam logic [23:0] COL_GRID  = 24'h000000;
   localparam logic [23:0] COL_BOX   = 24'hFFFFFF;

   typedef enum logic {
      DIR_INC = 1'b0,
      DIR_DEC = 1'b1
   } dir_e;

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position register plus
// a two-state direction FSM, advanced once per tick.
module vga_bounce_axis
   import vga_pkg::*;
#(
   parameter int W    = 11,
   parameter int LIM  = 960,
   parameter int STEP = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   output logic [W-1:0] pos,
   output dir_e         dir
);

   localparam logic [11:0] LIM_X  = 12'(LIM);
   localparam logic [11:0] STEP_X = 12'(STEP);

   logic [W-1:0] pos_q, pos_d;
   dir_e         dir_q, dir_d;
   logic [11:0]  pos_x;

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_q <= '0;
         dir_q <= DIR_INC;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   // Widened compares keep pos+STEP from wrapping near LIM.
   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      pos_x = 12'(pos_q);
      if (tick) begin
         unique case (dir_q)
            DIR_INC: begin
               if (pos_x + STEP_X >= LIM_X) begin
                  pos_d = W'(LIM);
                  dir_d = DIR_DEC;
               end else begin
                  pos_d = pos_q + W'(STEP);
               end
            end
            DIR_DEC: begin
               if (pos_x <= STEP_X) begin
                  pos_d = '0;
                  dir_d = DIR_INC;
               end else begin
                  pos_d = pos_q - W'(STEP);
               end
            end
            default: begin
               pos_d = pos_q;
               dir_d = dir_q;
            end
         endcase
      end
   end

   assign pos = pos_q;
   assign dir = dir_q;

endmodule

// File: rtl/vga_grid_render.sv
// Renders a grid with a bouncing box over incoming VGA
// timing; two register stages between syncs and rgb.
module vga_grid_render
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int GRID     = 48,
   parameter int BOX      = 64,
   parameter int STEP     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        de_in,
   input  logic        pause,
   output logic        hs_out,
   output logic        vs_out,
   output logic        de_out,
   output logic [23:0] rgb
);

   logic        de_prev_q, vs_prev_q;
   logic [10:0] x_q, x_d, gx_q, gx_d;
   logic [9:0]  y_q, y_d, gy_q, gy_d;

   logic        s1_hs_q, s1_vs_q, s1_de_q;
   logic        s1_grid_q, s1_box_q;
   logic        s1_grid_d, s1_box_d;
   logic        s2_hs_q, s2_vs_q, s2_de_q;
   logic [23:0] s2_rgb_q, s2_rgb_d;

   logic        de_fall, vs_fall, tick;
   logic [10:0] box_x;
   logic [9:0]  box_y;
   dir_e        x_dir_unused, y_dir_unused;
   logic [11:0] px, py, bx_lo, bx_hi, by_lo, by_hi;

   assign de_fall = de_prev_q & ~de_in;
   assign vs_fall = vs_prev_q & ~vs_in;
   assign tick    = vs_fall & ~pause;

   vga_bounce_axis #(
      .W    (11),
      .LIM  (H_ACTIVE - BOX),
      .STEP (STEP)
   ) u_axis_x (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .pos   (box_x),
      .dir   (x_dir_unused)
   );

   vga_bounce_axis #(
      .W    (10),
      .LIM  (V_ACTIVE - BOX),
      .STEP (STEP)
   ) u_axis_y (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .pos   (box_y),
      .dir   (y_dir_unused)
   );

   // x_q/gx_q hold the coordinate of the current de-high pixel.
   always_comb begin
      x_d  = '0;
      gx_d = '0;
      if (de_in) begin
         x_d  = x_q + 11'd1;
         gx_d = (gx_q == 11'(GRID - 1)) ? '0 : gx_q + 11'd1;
      end
      y_d  = y_q;
      gy_d = gy_q;
      if (vs_fall) begin
         y_d  = '0;
         gy_d = '0;
      end else if (de_fall) begin
         y_d  = y_q + 10'd1;
         gy_d = (gy_q == 10'(GRID - 1)) ? '0 : gy_q + 10'd1;
      end
   end

   always_comb begin
      px    = 12'(x_q);
      py    = 12'(y_q);
      bx_lo = 12'(box_x);
      by_lo = 12'(box_y);
      bx_hi = bx_lo + 12'(BOX);
      by_hi = by_lo + 12'(BOX);
      s1_grid_d = (gx_q == '0) || (gy_q == '0);
      s1_box_d  = (px >= bx_lo) && (px < bx_hi) &&
                  (py >= by_lo) && (py < by_hi);
   end

   always_comb begin
      if (!s1_de_q) begin
         s2_rgb_d = COL_BLANK;
      end else if (s1_box_q) begin
         s2_rgb_d = COL_BOX;
      end else if (s1_grid_q) begin
         s2_rgb_d = COL_GRID;
      end else begin
         s2_rgb_d = COL_BG;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         de_prev_q <= 1'b0;
         vs_prev_q <= 1'b1;
         x_q       <= '0;
         gx_q      <= '0;
         y_q       <= '0;
         gy_q      <= '0;
         s1_hs_q   <= 1'b1;
         s1_vs_q   <= 1'b1;
         s1_de_q   <= 1'b0;
         s1_grid_q <= 1'b0;
         s1_box_q  <= 1'b0;
         s2_hs_q   <= 1'b1;
         s2_vs_q   <= 1'b1;
         s2_de_q   <= 1'b0;
         s2_rgb_q  <= '0;
      end else begin
         de_prev_q <= de_in;
         vs_prev_q <= vs_in;
         x_q       <= x_d;
         gx_q      <= gx_d;
         y_q       <= y_d;
         gy_q      <= gy_d;
         s1_hs_q   <= hs_in;
         s1_vs_q   <= vs_in;
         s1_de_q   <= de_in;
         s1_grid_q <= s1_grid_d;
         s1_box_q  <= s1_box_d;
         s2_hs_q   <= s1_hs_q;
         s2_vs_q   <= s1_vs_q;
         s2_de_q   <= s1_de_q;
         s2_rgb_q  <= s2_rgb_d;
      end
   end

   assign hs_out = s2_hs_q;
   assign vs_out = s2_vs_q;
   assign de_out = s2_de_q;
   assign rgb    = s2_rgb_q;

endmodule

// File: tb/tb_vga_grid_render.sv
// Scoreboard bench for vga_grid_render: stimulus queues the
// expected output per cycle, a monitor checks it.
module tb_vga_grid_render;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        hs_in = 1'b1;
   logic        vs_in = 1'b1;
   logic        de_in = 1'b0;
   logic        pause = 1'b0;
   logic        hs_out, vs_out, de_out;
   logic [23:0] rgb;

   localparam logic [23:0] K = 24'h000000;
   localparam logic [23:0] W = 24'hFFFFFF;
   localparam logic [23:0] B = 24'hB93E06;

   typedef struct {
      int          cyc;
      logic [23:0] rgb;
      logic        hs;
      logic        vs;
      logic        de;
      string       nm;
   } exp_t;

   exp_t        sb[$];
   logic [23:0] want[int];
   string       tag;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;

   vga_grid_render dut (
      .clk    (clk),
      .reset  (reset),
      .hs_in  (hs_in),
      .vs_in  (vs_in),
      .de_in  (de_in),
      .pause  (pause),
      .hs_out (hs_out),
      .vs_out (vs_out),
      .de_out (de_out),
      .rgb    (rgb)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         if (e.cyc != cyc) begin
            n_err++;
            $display("FAIL %s: checked at cycle %0d, required cycle %0d",
                     e.nm, cyc, e.cyc);
         end else if (rgb !== e.rgb || hs_out !== e.hs ||
                      vs_out !== e.vs || de_out !== e.de) begin
            n_err++;
            $display("FAIL %s: got rgb=%h hs=%b vs=%b de=%b, want rgb=%h hs=%b vs=%b de=%b",
                     e.nm, rgb, hs_out, vs_out, de_out,
                     e.rgb, e.hs, e.vs, e.de);
         end
      end
   end

   task automatic push(input int at, input logic [23:0] c,
                       input logic hs, input logic vs,
                       input logic de, input string nm);
      exp_t e;
      e.cyc = at;
      e.rgb = c;
      e.hs  = hs;
      e.vs  = vs;
      e.de  = de;
      e.nm  = nm;
      sb.push_back(e);
   endtask

   task automatic drive(input logic hs, input logic vs, input logic de,
                        input bit chk, input logic [23:0] c,
                        input string nm);
      hs_in = hs;
      vs_in = vs;
      de_in = de;
      if (chk) push(cyc + 2, c, hs, vs, de, nm);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string nm);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         hs_in = 1'b0;
         vs_in = 1'b0;
         de_in = 1'b1;
         push(cyc + 1, K, 1'b1, 1'b1, 1'b0, $sformatf("%s_rst%0d", nm, i));
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      hs_in = 1'b1;
      vs_in = 1'b1;
      de_in = 1'b0;
      push(cyc + 1, K, 1'b1, 1'b1, 1'b0, $sformatf("%s_rel", nm));
      @(posedge clk);
      #1;
      drive(1, 1, 0, 0, K, "");
   endtask

   task automatic vsync();
      drive(1, 0, 0, 0, K, "");
      drive(1, 0, 0, 0, K, "");
      drive(1, 1, 0, 0, K, "");
   endtask

   task automatic short_lines(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1, 1, 1, 0, K, "");
         drive(1, 1, 0, 0, K, "");
      end
   endtask

   task automatic long_line(input int hs_at);
      for (int i = 0; i < 1024; i++) begin
         logic hs;
         bit   chk;
         hs  = (hs_at >= 0 && i >= hs_at && i < hs_at + 8) ? 1'b0 : 1'b1;
         chk = want.exists(i);
         drive(hs, 1, 1, chk, chk ? want[i] : K,
               $sformatf("%s_x%0d", tag, i));
      end
      want.delete();
      drive(1, 1, 0, 1, K, {tag, "_blank"});
      drive(1, 1, 0, 0, K, "");
   endtask

   initial begin
      do_reset("r0");

      // box at (0,0) right after reset, line y=10
      short_lines(10);
      tag = "y10";
      want[0] = W; want[31] = W; want[48] = W; want[63] = W;
      want[64] = B; want[96] = K;
      long_line(-1);

      // new frame, line y=100, hsync falls 5 pixels into de
      vsync();
      short_lines(100);
      drive(1, 1, 0, 1, K, "pre_de");
      tag = "y100";
      want[0] = K; want[1] = B; want[4] = B; want[5] = B;
      want[48] = K; want[49] = B; want[96] = K;
      long_line(5);

      // bounce sequence from a fresh reset
      do_reset("r1");
      repeat (176) vsync();
      short_lines(703);
      tag = "f176_y703";
      want[704] = B;
      long_line(-1);
      tag = "f176_y704";
      want[703] = B; want[704] = W; want[767] = W; want[768] = K;
      long_line(-1);

      vsync();
      short_lines(699);
      tag = "f177_y699";
      want[708] = B;
      long_line(-1);
      tag = "f177_y700";
      want[707] = B; want[708] = W;
      long_line(-1);

      repeat (63) vsync();
      short_lines(447);
      tag = "f240_y447";
      want[960] = K;
      long_line(-1);
      tag = "f240_y448";
      want[959] = B; want[960] = W; want[1023] = W;
      long_line(-1);

      vsync();
      short_lines(444);
      tag = "f241_y444";
      want[955] = B; want[956] = W; want[1019] = W; want[1020] = B;
      long_line(-1);

      // paused frames keep the box still
      pause = 1'b1;
      repeat (3) vsync();
      pause = 1'b0;
      short_lines(444);
      tag = "paused_y444";
      want[955] = B; want[956] = W; want[1019] = W; want[1020] = B;
      long_line(-1);

      vsync();
      short_lines(440);
      tag = "resume_y440";
      want[951] = B; want[952] = W; want[1015] = W; want[1016] = B;
      long_line(-1);

      repeat (4) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL %s: never checked, required at cycle %0d", e.nm, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_grid_render.md
VGA_GRID_RENDER -- requirements
Module: vga_grid_render

Interface
REQ-001 Parameter H_ACTIVE, 1024, visible pixels per line.
REQ-002 Parameter V_ACTIVE, 768, visible lines per frame.
REQ-003 Parameter GRID, 48, grid pitch in pixels on both axes.
REQ-004 Parameter BOX, 64, square box edge in pixels.
REQ-005 Parameter STEP, 4, box movement per frame in pixels on each axis.
REQ-006 Port clk input 1, pixel clock; the block uses one clock.
REQ-007 Port reset input 1, synchronous active-high reset.
REQ-008 Port hs_in input 1, active-low hsync from the timing stage.
REQ-009 Port vs_in input 1, active-low vsync from the timing stage.
REQ-010 Port de_in input 1, active-video strobe from the timing stage.
REQ-011 Port pause input 1, freezes box motion while high.
REQ-012 Port hs_out, vs_out, de_out output 1 each, inputs delayed to align with rgb.
REQ-013 Port rgb output 24, pixel colour {R[23:16],G[15:8],B[7:0]}.

Function
REQ-014 The x counter SHALL be 0 on the first de_in-high cycle of a line, +1 on each further de_in-high cycle, and 0 while de_in is low.
REQ-015 The y counter SHALL increment on each de_in falling edge and clear to 0 on each vs_in falling edge; a vs_in falling edge on the same cycle as a de_in falling edge clears it.
REQ-016 Pitch counters gx/gy SHALL track x mod GRID and y mod GRID incrementally (no divider): gx wraps GRID-1->0 and clears with x; gy wraps on de_in fall and clears with y.
REQ-017 A pixel SHALL be grid when gx==0 or gy==0.
REQ-018 A pixel SHALL be box when box_x<=x<box_x+BOX and box_y<=y<box_y+BOX.
REQ-019 Colour priority: de low -> 24'h000000; box -> 24'hFFFFFF; grid -> 24'h000000; else 24'hB93E06.
REQ-020 The pipeline SHALL have exactly 2 cycles of latency: stage 1 registers syncs, de, x, and grid/box flags; stage 2 registers colour; hs_out/vs_out/de_out equal the inputs delayed by 2 cycles.
REQ-021 Each axis SHALL have a direction FSM: X in {RIGHT, LEFT}, Y in {DOWN, UP}; updates happen only on a vs_in falling edge with pause low.
REQ-022 RIGHT/DOWN: if pos+STEP >= LIM (LIM = H_ACTIVE-BOX or V_ACTIVE-BOX), then pos<=LIM and the direction flips; else pos<=pos+STEP.
REQ-023 LEFT/UP: if pos <= STEP, then pos<=0 and the direction flips to RIGHT/DOWN; else pos<=pos-STEP.
REQ-024 Position registers SHALL be 11 bits (x) and 10 bits (y); comparisons SHALL use 12-bit extended sums so pos+BOX never wraps.
REQ-025 If pause is high at a vs_in falling edge, position and direction SHALL hold; the counters of REQ-014..016 still run.

Reset
REQ-026 While reset is high at a clk edge: x, y, gx, gy = 0; box_x = box_y = 0; X = RIGHT, Y = DOWN; both pipeline stages cleared; hs_out = vs_out = 1, de_out = 0, rgb = 0.
REQ-027 Edge detectors for de_in/vs_in SHALL reset to their inactive values (de 0, vs 1), so no edge is detected on the first cycle after reset.
REQ-028 After reset is released mid-frame, y counts from 0 until the next vs_in falling edge resynchronises it; this is accepted behaviour.

Structure
REQ-029 Package vga_pkg SHALL hold the colour constants (COL_BG, COL_GRID, COL_BOX) and the default H_ACTIVE/V_ACTIVE shared with the timing stage.
REQ-030 One sub-module, vga_bounce_axis (parameters LIM and STEP; ports clk, reset, tick, pos, dir), SHALL be instantiated once per axis.

Verification
REQ-031 Reset high 4 cycles -> rgb=0, hs_out=1, vs_out=1, de_out=0 throughout, and 1 cycle after release.
REQ-032 Frame start, line y=100 with de high for 1024 cycles -> x=0,48,96 give 000000; x=1,49 give B93E06.
REQ-033 Line y=10 after reset (box at 0,0) -> x=0..63 give FFFFFF; x=64 gives B93E06; x=96 gives 000000.
REQ-034 de_in rises at cycle t, hs_in falls at t+5 -> de_out rises at t+2, hs_out falls at t+7, and the first rgb for x=0 appears at t+2.
REQ-035 240 vsyncs with pause=0 -> box_x=960, X=LEFT; 241st -> 956. 176 vsyncs -> box_y=704, Y=UP; 177th -> 700.
REQ-036 pause=1 across 3 vsyncs, then pause=0 -> box position unchanged for those 3 frames; motion resumes at the next vsync.
